// File: rtl/md_sched.sv
// md_sched: issue and sequencing controller for the shared iterative
// HI/LO multiply-divide unit in the E stage.
//
// Accepts mult/multu/div/divu and mthi/mtlo requests, issues them to the
// unit with same-cycle strobes and tracks each multi-cycle operation with
// a countdown. Generates busy/done and the D-stage stall for mfhi/mflo and
// back-to-back MD instructions. An asserted flush freezes sequencing in
// lockstep with the unit.
//
// Parameters:
//   MUL_LAT     cycles from issue to result for mult/multu (>= 1)
//   DIV_LAT     cycles from issue to result for div/divu   (>= 1)
// Ports:
//   clk, reset  clock; synchronous active-high reset
//   req_valid   E-stage MD request present
//   req_op      000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//               110/111 no-op
//   req_ready   request accepted this cycle when high with req_valid
//   rd_valid    D stage holds mfhi/mflo
//   md_valid_d  D stage holds any MD-class instruction
//   flush       exception/interrupt; freezes the block
//   start       one-cycle issue strobe to the unit
//   op_out      op code issued with start/wr_hi/wr_lo, else 000
//   wr_hi       write-HI strobe (mthi)
//   wr_lo       write-LO strobe (mtlo)
//   busy        multi-cycle operation in flight
//   done        one-cycle pulse in the last busy cycle
//   stall_d     D-stage stall request
module md_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic       rd_valid,
  input  logic       md_valid_d,
  input  logic       flush,
  output logic       start,
  output logic [2:0] op_out,
  output logic       wr_hi,
  output logic       wr_lo,
  output logic       busy,
  output logic       done,
  output logic       stall_d
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    op_out  = '0;
    done    = 1'b0;

    req_ready = (state_q == S_IDLE) && !flush;
    // A request seen while reset is high must not produce strobes.
    accept    = req_valid && req_ready && !reset;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            3'b000, 3'b001: begin
              start   = 1'b1;
              op_out  = req_op;
              state_d = S_RUN;
              cnt_d   = MUL_CNT;
            end
            3'b010, 3'b011: begin
              start   = 1'b1;
              op_out  = req_op;
              state_d = S_RUN;
              cnt_d   = DIV_CNT;
            end
            3'b100: begin
              wr_hi  = 1'b1;
              op_out = req_op;
            end
            3'b101: begin
              wr_lo  = 1'b1;
              op_out = req_op;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Flush freezes the countdown; the unit holds its state too.
        if (!flush && !reset) begin
          cnt_d = cnt_q - ONE_CNT;
          if (cnt_q == ONE_CNT) begin
            done    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy    = (state_q == S_RUN);
    stall_d = (rd_valid || md_valid_d) && (busy || start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (MUL_LAT=5, DIV_LAT=10).
// Inputs change 1 ns after each rising edge; outputs are sampled 4 ns later.
module tb_md_sched;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_op;
  logic       req_ready;
  logic       rd_valid;
  logic       md_valid_d;
  logic       flush;
  logic       start;
  logic [2:0] op_out;
  logic       wr_hi;
  logic       wr_lo;
  logic       busy;
  logic       done;
  logic       stall_d;

  int unsigned n_checks;
  int unsigned n_fail;

  md_sched #(
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rd_valid  (rd_valid),
    .md_valid_d(md_valid_d),
    .flush     (flush),
    .start     (start),
    .op_out    (op_out),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .busy      (busy),
    .done      (done),
    .stall_d   (stall_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    rd_valid   = 1'b0;
    md_valid_d = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    #1;
    next_cycle();
    next_cycle();

    // Reset state (reset still high, flush low)
    #4;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_start", start, 0);
    check_eq("rst_op", op_out, 0);
    check_eq("rst_stall", stall_d, 0);
    check_eq("rst_ready", req_ready, 1);
    // Request while reset is high: ignored
    req_valid = 1'b1;
    req_op    = 3'b000;
    #1;
    check_eq("rst_req_start", start, 0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #4;
    check_eq("rst_req_busy", busy, 0);
    next_cycle();

    // mult at T0, md_valid_d held
    for (int t = 0; t <= 6; t++) begin
      req_valid  = (t == 0);
      req_op     = 3'b000;
      md_valid_d = 1'b1;
      #4;
      check_eq($sformatf("mul_start_t%0d", t), start, (t == 0));
      check_eq($sformatf("mul_busy_t%0d", t), busy, (t >= 1 && t <= 5));
      check_eq($sformatf("mul_done_t%0d", t), done, (t == 5));
      check_eq($sformatf("mul_ready_t%0d", t), req_ready, (t == 0 || t == 6));
      check_eq($sformatf("mul_stall_t%0d", t), stall_d, (t <= 5));
      next_cycle();
    end
    idle_inputs();

    // divu at T0 with flush at T3..T4
    for (int t = 0; t <= 13; t++) begin
      req_valid = (t == 0);
      req_op    = 3'b011;
      flush     = (t == 3 || t == 4);
      #4;
      check_eq($sformatf("divu_start_t%0d", t), start, (t == 0));
      check_eq($sformatf("divu_op_t%0d", t), op_out, (t == 0) ? 3 : 0);
      check_eq($sformatf("divu_busy_t%0d", t), busy, (t >= 1 && t <= 12));
      check_eq($sformatf("divu_done_t%0d", t), done, (t == 12));
      next_cycle();
    end
    idle_inputs();

    // mthi at T0, mtlo at T1
    for (int t = 0; t <= 2; t++) begin
      req_valid = (t <= 1);
      req_op    = (t == 0) ? 3'b100 : 3'b101;
      #4;
      check_eq($sformatf("mthl_wrhi_t%0d", t), wr_hi, (t == 0));
      check_eq($sformatf("mthl_wrlo_t%0d", t), wr_lo, (t == 1));
      check_eq($sformatf("mthl_op_t%0d", t), op_out,
               (t == 0) ? 4 : ((t == 1) ? 5 : 0));
      check_eq($sformatf("mthl_busy_t%0d", t), busy, 0);
      check_eq($sformatf("mthl_start_t%0d", t), start, 0);
      next_cycle();
    end
    idle_inputs();

    // div at T0 with rd_valid held
    for (int t = 0; t <= 11; t++) begin
      req_valid = (t == 0);
      req_op    = 3'b010;
      rd_valid  = 1'b1;
      #4;
      check_eq($sformatf("divrd_stall_t%0d", t), stall_d, (t <= 10));
      next_cycle();
    end
    idle_inputs();

    // div at T0, second div presented continuously from T1
    for (int t = 0; t <= 11; t++) begin
      req_valid = 1'b1;
      req_op    = 3'b010;
      #4;
      check_eq($sformatf("b2b_start_t%0d", t), start, (t == 0 || t == 11));
      check_eq($sformatf("b2b_done_t%0d", t), done, (t == 10));
      check_eq($sformatf("b2b_op_t%0d", t), op_out,
               (t == 0 || t == 11) ? 2 : 0);
      next_cycle();
    end
    idle_inputs();

    // Reset during the second div abandons it
    do_reset();
    #4;
    check_eq("b2b_rst_busy", busy, 0);
    next_cycle();

    // mult at T0, reset at T3
    for (int t = 0; t <= 8; t++) begin
      req_valid = (t == 0);
      req_op    = 3'b001;
      reset     = (t == 3);
      #4;
      check_eq($sformatf("mrst_done_t%0d", t), done, 0);
      check_eq($sformatf("mrst_busy_t%0d", t), busy, (t >= 1 && t <= 3));
      if (t >= 4) check_eq($sformatf("mrst_ready_t%0d", t), req_ready, 1);
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();

    // op 110 accepted: no strobes, no state change
    req_valid = 1'b1;
    req_op    = 3'b110;
    #4;
    check_eq("nop_ready", req_ready, 1);
    check_eq("nop_strobes", {start, wr_hi, wr_lo}, 0);
    check_eq("nop_op", op_out, 0);
    next_cycle();
    idle_inputs();
    #4;
    check_eq("nop_busy", busy, 0);
    check_eq("nop_ready2", req_ready, 1);
    next_cycle();

    // mult and mthi presented with flush high
    for (int t = 0; t <= 2; t++) begin
      req_valid = 1'b1;
      req_op    = (t == 1) ? 3'b100 : 3'b000;
      flush     = 1'b1;
      #4;
      check_eq($sformatf("fl_ready_t%0d", t), req_ready, 0);
      check_eq($sformatf("fl_strobes_t%0d", t), {start, wr_hi, wr_lo}, 0);
      check_eq($sformatf("fl_busy_t%0d", t), busy, 0);
      next_cycle();
    end
    idle_inputs();
    #4;
    check_eq("fl_after_busy", busy, 0);
    check_eq("fl_after_ready", req_ready, 1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
